// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage state type, PC constants and word-index helper.
package instr_fetch_pkg;
   typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] PC_INCR = 32'd4;
   function automatic logic [31:0] pc_to_word_index(input logic [31:0] pc, input logic [31:0] base);
      return (pc - base) >> 2;
   endfunction
endpackage

// File: rtl/instr_fetch_unit_redirect.sv
// fetch_redirect_ctrl: pending-redirect latch and next-PC priority mux with
// fault screening of the candidate next PC.
module fetch_redirect_ctrl
   import instr_fetch_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 32,
   parameter logic [BIT_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned ROM_WORDS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 stall,
   input  logic                 jump,
   input  logic [BIT_WIDTH-1:0] jump_target,
   input  logic                 branch,
   input  logic [BIT_WIDTH-1:0] branch_target,
   input  logic [BIT_WIDTH-1:0] pc,
   output logic [BIT_WIDTH-1:0] next_pc,
   output logic                 fault_candidate
);
   logic                 pending;
   logic [BIT_WIDTH-1:0] pending_target;
   // first redirect seen during a stall wins; it is consumed when the PC next advances
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending        <= 1'b0;
         pending_target <= '0;
      end else if (en && stall && !pending && (jump || branch)) begin
         pending        <= 1'b1;
         pending_target <= jump ? jump_target : branch_target;
      end else if (en && !stall) begin
         pending <= 1'b0;
      end
   end
   assign next_pc = pending ? pending_target : jump ? jump_target : branch ? branch_target : pc + PC_INCR;
   assign fault_candidate = (|next_pc[1:0]) || (next_pc < RESET_PC) ||
                            (pc_to_word_index(next_pc, RESET_PC) >= ROM_WORDS);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, ROM addressing and instruction register with
// stall/redirect/fault handling; optional counters under FETCH_PERF_COUNT_EN.
module instr_fetch_unit
   import instr_fetch_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 32,
   parameter logic [BIT_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned ROM_WORDS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall_in,
   input  logic                 branch_taken_in,
   input  logic [BIT_WIDTH-1:0] branch_target_in,
   input  logic                 jump_in,
   input  logic [BIT_WIDTH-1:0] jump_target_in,
   output logic [BIT_WIDTH-1:0] rom_addr_out,
   input  logic [BIT_WIDTH-1:0] rom_data_in,
   output logic [BIT_WIDTH-1:0] instr_out,
   output logic [BIT_WIDTH-1:0] pc_out,
   output logic [BIT_WIDTH-1:0] pc_plus4_out,
   output logic                 instr_valid_out,
`ifdef FETCH_PERF_COUNT_EN
   output logic                 addr_fault_out,
   output logic [BIT_WIDTH-1:0] fetch_count_out,
   output logic [BIT_WIDTH-1:0] stall_count_out
`else
   output logic                 addr_fault_out
`endif
);
   fetch_state_t         state, state_nxt;
   logic [BIT_WIDTH-1:0] pc, next_pc;
   logic                 fault_cand, active, advance;
   assign active       = state != FAULT;
   assign advance      = active && !stall_in;
   assign rom_addr_out = pc_to_word_index(pc, RESET_PC);
   assign pc_plus4_out = pc_out + PC_INCR;

   fetch_redirect_ctrl #(.BIT_WIDTH(BIT_WIDTH), .RESET_PC(RESET_PC), .ROM_WORDS(ROM_WORDS)) u_redirect (
      .clk(clk), .rst_n(rst_n), .en(active), .stall(stall_in),
      .jump(jump_in), .jump_target(jump_target_in),
      .branch(branch_taken_in), .branch_target(branch_target_in),
      .pc(pc), .next_pc(next_pc), .fault_candidate(fault_cand)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      state_nxt = advance ? (fault_cand ? FAULT : RUN) : state;
   end

   // a faulting edge drops the current fetch and leaves the PC on its last good value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc              <= RESET_PC;
         instr_out       <= '0;
         pc_out          <= RESET_PC;
         instr_valid_out <= 1'b0;
         addr_fault_out  <= 1'b0;
      end else if (advance && fault_cand) begin
         instr_valid_out <= 1'b0;
         addr_fault_out  <= 1'b1;
      end else if (advance) begin
         pc              <= next_pc;
         instr_out       <= rom_data_in;
         pc_out          <= pc;
         instr_valid_out <= 1'b1;
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count_out <= '0;
         stall_count_out <= '0;
      end else begin
         if (advance && !fault_cand && !(&fetch_count_out)) fetch_count_out <= fetch_count_out + 1'b1;
         if (state == RUN && stall_in && !(&stall_count_out)) stall_count_out <= stall_count_out + 1'b1;
      end
   end
`else
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks of the fetch unit against
// a behavioural model of fetch, delay-slot redirect, stall and fault rules.
module tb_instr_fetch_unit;
   localparam logic [31:0] BASE = 32'h0040_0000;
   localparam int NW = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_in = 1'b0, branch_taken_in = 1'b0, jump_in = 1'b0;
   logic [31:0] branch_target_in = '0, jump_target_in = '0;
   logic [31:0] rom_addr_out, rom_data_in, instr_out, pc_out, pc_plus4_out;
   logic        instr_valid_out, addr_fault_out;
   logic [31:0] rom [NW];

   int vectors = 0, miscompares = 0;
   bit chk_en = 1'b0;

   // model state
   logic [31:0] m_pc, m_instr, m_pc_out, m_tgt;
   bit          m_valid, m_fault, m_pend;
   int          m_st;

   always #5 clk = ~clk;
   assign rom_data_in = rom[rom_addr_out[4:0]];

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
      .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
      .jump_in(jump_in), .jump_target_in(jump_target_in),
      .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
      .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
      .instr_valid_out(instr_valid_out), .addr_fault_out(addr_fault_out)
   );

   function automatic bit bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) / 4) >= NW);
   endfunction

   always @(posedge clk) begin
      logic [31:0] np;
      if (!rst_n) begin
         m_pc = BASE; m_instr = 0; m_pc_out = BASE; m_valid = 0; m_fault = 0; m_pend = 0; m_st = 0;
      end else if (m_st != 2 && !stall_in) begin
         np = m_pend ? m_tgt : jump_in ? jump_target_in : branch_taken_in ? branch_target_in : m_pc + 4;
         m_pend = 0;
         if (bad_addr(np)) begin
            m_fault = 1; m_valid = 0; m_st = 2;
         end else begin
            m_instr = rom[(m_pc - BASE) / 4]; m_pc_out = m_pc; m_valid = 1; m_pc = np; m_st = 1;
         end
      end else if (m_st != 2 && (jump_in || branch_taken_in) && !m_pend) begin
         m_pend = 1; m_tgt = jump_in ? jump_target_in : branch_target_in;
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", 32'(instr_valid_out), 32'(m_valid));
         chk("fault", 32'(addr_fault_out), 32'(m_fault));
         chk("rom_addr", rom_addr_out, (m_pc - BASE) >> 2);
         chk("instr", instr_out, m_instr);
         chk("pc_out", pc_out, m_pc_out);
         chk("pc_plus4", pc_plus4_out, m_pc_out + 4);
      end
   end

   task automatic cyc(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
      rst_n = !rst; stall_in = st; branch_taken_in = br; branch_target_in = bt;
      jump_in = j; jump_target_in = jt;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_tgt();
      case ($urandom_range(0, 19))
         0:       return BASE + 4 * $urandom_range(0, NW - 1) + $urandom_range(1, 3);
         1:       return BASE - 4 * $urandom_range(1, 8);
         2:       return BASE + 4 * $urandom_range(NW, NW + 8);
         default: return BASE + 4 * $urandom_range(0, NW - 1);
      endcase
   endfunction

   initial begin
      int fault_age;
      for (int i = 0; i < NW; i++) rom[i] = $urandom;
      rom[0] = 32'h2008_000F;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_valid", 32'(instr_valid_out), 0);
      chk("rst_pc_out", pc_out, 32'h0040_0000);
      chk("rst_pc4", pc_plus4_out, 32'h0040_0004);
      chk("rst_rom_addr", rom_addr_out, 0);
      chk("rst_fault", 32'(addr_fault_out), 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("boot_valid", 32'(instr_valid_out), 1);
      chk("boot_instr", instr_out, 32'h2008_000F);
      chk("boot_pc_out", pc_out, 32'h0040_0000);
      chk("boot_pc4", pc_plus4_out, 32'h0040_0004);
      chk("boot_rom_addr", rom_addr_out, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("seq_pc1", pc_out, 32'h0040_0004);
      chk("seq_instr1", instr_out, rom[1]);
      cyc(0, 0, 0, 0, 0, 0);
      chk("seq_pc2", pc_out, 32'h0040_0008);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         chk("stall_pc", pc_out, 32'h0040_0008);
         chk("stall_rom_addr", rom_addr_out, 3);
      end
      cyc(0, 0, 0, 0, 0, 0);
      chk("resume_pc", pc_out, 32'h0040_000C);
      cyc(0, 0, 1, 32'h0040_0040, 0, 0);
      chk("delay_slot_pc", pc_out, 32'h0040_0010);
      chk("delay_slot_instr", instr_out, rom[4]);
      cyc(0, 0, 0, 0, 0, 0);
      chk("branch_pc", pc_out, 32'h0040_0040);
      cyc(0, 0, 1, 32'h0040_0060, 1, 32'h0040_0050);
      chk("jb_slot_pc", pc_out, 32'h0040_0044);
      cyc(0, 0, 0, 0, 0, 0);
      chk("jump_prio_pc", pc_out, 32'h0040_0050);
      cyc(0, 1, 0, 0, 1, 32'h0040_0020);
      cyc(0, 1, 1, 32'h0040_0030, 0, 0);
      chk("pend_hold_pc", pc_out, 32'h0040_0050);
      cyc(0, 0, 0, 0, 0, 0);
      chk("pend_rom_addr", rom_addr_out, 8);
      cyc(0, 0, 0, 0, 0, 0);
      chk("pend_pc", pc_out, 32'h0040_0020);
      cyc(0, 0, 0, 0, 1, 32'h0040_0006);
      chk("mis_fault", 32'(addr_fault_out), 1);
      chk("mis_valid", 32'(instr_valid_out), 0);
      chk("mis_rom_addr", rom_addr_out, 9);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 32'h0040_0000, 0, 0);
         chk("frozen_rom_addr", rom_addr_out, 9);
      end
      cyc(1, 0, 0, 0, 0, 0);
      chk("clr_fault", 32'(addr_fault_out), 0);
      cyc(0, 0, 0, 0, 1, 32'h0040_0080);
      chk("oob_fault", 32'(addr_fault_out), 1);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h0040_007C);
      cyc(0, 0, 0, 0, 0, 0);
      chk("runoff_fault", 32'(addr_fault_out), 1);
      cyc(1, 0, 0, 0, 0, 0);
      fault_age = 0;
      for (int n = 0; n < 3000; n++) begin
         bit r;
         fault_age = (m_st == 2) ? fault_age + 1 : 0;
         r = (fault_age > 2) || ($urandom_range(0, 199) == 0);
         cyc(r, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rand_tgt(),
             $urandom_range(0, 19) == 0, rand_tgt());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
